stream_mux_rr: RTL
==================

Name: stream_mux_rr

Overview:
Parametrised N-channel streaming multiplexer. It is the sequential successor to the combinational 4:1 mux.
- Selects one of CH input streams onto a single registered output.
- Two selection modes: fixed select from `sel`, or round-robin arbitration.
- Valid/ready handshake on every port; selection is locked for the whole of a packet, which is delimited by `last`.
- Sits between multiple producers and one shared downstream consumer.

Parameters:
- WIDTH, 8, data bits per channel
- CH, 4, number of input channels (2..16)
- SELW, 2, select/channel-index width; must satisfy 2**SELW >= CH

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- in_data  input  CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  CH  per-channel valid
- in_last  input  CH  per-channel end-of-packet flag
- in_ready  output  CH  per-channel ready
- sel  input  SELW  channel select, used when rr_en=0
- rr_en  input  1  1 = round-robin mode, 0 = fixed-select mode
- out_data  output  WIDTH  registered output data
- out_valid  output  1  output valid
- out_last  output  1  registered end-of-packet flag
- out_ch  output  SELW  index of the channel that sourced the current output beat
- out_ready  input  1  downstream ready

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is asynchronous and active-high.
- Reset values: out_valid=0, out_data=0, out_last=0, out_ch=0, state=IDLE, rr_ptr=CH-1. With rr_ptr=CH-1, the first round-robin search starts at channel 0.
- Load enable: load_ok = !out_valid || out_ready.
- Accept: a beat on channel i is accepted when in_valid[i] && in_ready[i].
- in_ready[i] = load_ok && (grant==i) && grant_vld. At most one in_ready bit is high in any cycle.
- Output register: loads on accept. out_data, out_last and out_ch take the accepted beat's values; out_valid becomes 1.
- Output drain: if out_ready is high and nothing is accepted, out_valid clears to 0 on the next edge.
- Latency and throughput: 1 cycle from accept to out_valid. Sustains 1 beat/cycle when out_ready is held high.
- Output stability: while out_valid=1 and out_ready=0, out_data, out_last and out_ch hold stable.
- State IDLE, grant computed combinationally:
  - rr_en=0: grant=sel; grant_vld = (sel < CH). If sel >= CH, all in_ready are low.
  - rr_en=1: grant is the first channel j with in_valid[j]=1, searching (rr_ptr+1) mod CH upward with wrap-around. grant_vld=0 if no channel is valid.
  - On accept with in_last=0: lock_ch=grant, move to LOCKED, rr_ptr=grant.
  - On accept with in_last=1 (single-beat packet): stay IDLE, rr_ptr=grant.
- State LOCKED:
  - grant=lock_ch and grant_vld=1. sel, rr_en and the other channels' valid are ignored.
  - On accept with in_last=1: move to IDLE. Arbitration for the next packet happens the following cycle, so there is no bubble beyond that cycle.
  - If the locked channel's in_valid drops mid-packet, stay LOCKED and wait; no other channel is granted.
- Mode change:
  - rr_en or sel changing while LOCKED takes effect only after returning to IDLE.
  - rr_ptr is updated only in round-robin mode; in fixed mode it holds.
- Reset mid-packet: immediately forces IDLE and clears out_valid. Any partially transferred packet is abandoned; no recovery beat is emitted.
- Simultaneous events:
  - Output drain and a new load in the same cycle: out_valid stays 1 with the new beat.
  - Last beat accepted while other channels are valid: the next grant follows the round-robin order from the new rr_ptr.

Test Plan:
- Reset: assert rst for 2 cycles with random inputs -> out_valid=0, out_data=0, out_ch=0, all in_ready=0.
- Fixed mode: rr_en=0, sel=2, in_data ch0..3 = 0x11/0x22/0xA5/0x44, all valid, in_last=1, out_ready=1 -> cycle+1 out_data=0xA5, out_ch=2; in_ready=4'b0100 continuously.
- Round-robin fairness: rr_en=1, all 4 channels continuously valid with single-beat packets -> out_ch sequence 0,1,2,3,0,1 on consecutive cycles.
- Packet lock: rr_en=1; ch1 sends 3 beats 0x01,0x02,0x03 (last on the third); ch0 and ch2 valid throughout -> out_ch=1 for all 3 beats. Next grants are ch2 then ch0. in_ready[0] and in_ready[2] stay 0 during the packet.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1, out_data=0x22 -> out_data holds 0x22 and all in_ready=0. Raising out_ready then drains the beat and accepts the next beat in that same cycle.
- Reset mid-packet and out-of-range select:
  - rst asserted after beat 2 of a 3-beat packet -> out_valid=0 immediately and state returns to IDLE.
  - After reset, rr_en=0 with sel=3 and CH=3 -> no in_ready and out_valid stays 0.

Source files
------------

// File: rtl/stream_mux_rr.sv
// N-channel stream mux, fixed-select or round-robin, packet-locked on `last`.
// 1-cycle accept->out_valid; inputs stall (in_ready low) while the output register is full and out_ready is low.
module stream_mux_rr #(
    parameter int WIDTH = 8,
    parameter int CH    = 4,
    parameter int SELW  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CH*WIDTH-1:0]   in_data,
    input  logic [CH-1:0]         in_valid,
    input  logic [CH-1:0]         in_last,
    output logic [CH-1:0]         in_ready,
    input  logic [SELW-1:0]       sel,
    input  logic                  rr_en,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    output logic                  out_last,
    output logic [SELW-1:0]       out_ch,
    input  logic                  out_ready
);

    typedef enum logic [0:0] {IDLE, LOCKED} state_t;

    state_t            state_q, state_d;
    logic [SELW-1:0]   lock_ch_q, lock_ch_d;
    logic [SELW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0]  out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic [SELW-1:0]   out_ch_q, out_ch_d;

    logic [SELW-1:0]   grant;
    logic              grant_vld;
    logic [SELW-1:0]   rr_idx;
    logic              load_ok;
    logic              accept;
    logic [WIDTH-1:0]  acc_data;
    logic              acc_last;

    assign load_ok = !out_valid_q || out_ready;

    // Descending scan so the lowest offset from rr_ptr+1 wins without a break.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        rr_idx    = '0;
        if (state_q == LOCKED) begin
            grant     = lock_ch_q;
            grant_vld = 1'b1;
        end else if (!rr_en) begin
            grant     = sel;
            grant_vld = (int'(sel) < CH);
        end else begin
            for (int k = CH; k >= 1; k--) begin
                rr_idx = SELW'((int'(rr_ptr_q) + k) % CH);
                if (in_valid[rr_idx]) begin
                    grant     = rr_idx;
                    grant_vld = 1'b1;
                end
            end
        end
    end

    always_comb begin
        in_ready = '0;
        acc_data = '0;
        acc_last = 1'b0;
        for (int i = 0; i < CH; i++) begin
            if (grant_vld && (grant == SELW'(i))) begin
                in_ready[i] = load_ok && !rst;
                acc_data    = in_data[i*WIDTH +: WIDTH];
                acc_last    = in_last[i];
            end
        end
    end

    assign accept = |(in_valid & in_ready);

    always_comb begin
        state_d     = state_q;
        lock_ch_d   = lock_ch_q;
        rr_ptr_d    = rr_ptr_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_ch_d    = out_ch_q;

        if (accept) begin
            out_data_d  = acc_data;
            out_last_d  = acc_last;
            out_ch_d    = grant;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            if (state_q == IDLE) begin
                if (rr_en) begin
                    rr_ptr_d = grant;
                end
                if (!acc_last) begin
                    state_d   = LOCKED;
                    lock_ch_d = grant;
                end
            end else if (acc_last) begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            lock_ch_q   <= '0;
            rr_ptr_q    <= SELW'(CH - 1);
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_ch_q    <= '0;
        end else begin
            state_q     <= state_d;
            lock_ch_q   <= lock_ch_d;
            rr_ptr_q    <= rr_ptr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_ch_q    <= out_ch_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_ch    = out_ch_q;

endmodule
